// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor.
//   bp_state_e      : INIT (table sweep) / RUN (serving requests)
//   DEF_*           : default parameter values
//   weak_not_taken(): weakly-not-taken counter value (MSB=0, lower bits=1)
package bp_pkg;

    localparam int unsigned DEF_CTR_WIDTH  = 2;
    localparam int unsigned DEF_INDEX_BITS = 6;
    localparam int unsigned DEF_HIST_BITS  = 6;
    localparam int unsigned DEF_PC_WIDTH   = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Result is 8 bits wide; callers truncate to CTR_WIDTH (2..4).
    function automatic logic [7:0] weak_not_taken(input int unsigned ctr_width);
        return 8'((32'd1 << (ctr_width - 32'd1)) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_next.sv
// Saturating up/down counter step.
//   count        : current counter value
//   taken        : 1 = increment, 0 = decrement
//   next_count_c : updated value, clamped at all-ones and at zero
module bp_sat_next
    import bp_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = DEF_CTR_WIDTH
) (
    input  logic [CTR_WIDTH-1:0] count,
    input  logic                 taken,
    output logic [CTR_WIDTH-1:0] next_count_c
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    always_comb begin
        next_count_c = count;
        if (taken) begin
            if (count != CTR_MAX) next_count_c = count + CTR_WIDTH'(1);
        end else begin
            if (count != '0) next_count_c = count - CTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor with a self-initialising counter table.
//   clk, rst                 : clock, synchronous active-high reset
//   pred_req, pred_pc        : prediction request
//   pred_valid/taken/index   : registered result, one cycle after the request
//   upd_valid/index/taken    : resolved-branch update
//   ready                    : table initialised, traffic accepted
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned CTR_WIDTH  = DEF_CTR_WIDTH,
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned HIST_BITS  = DEF_HIST_BITS,
    parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_req,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic                  ready
);

    localparam int unsigned            DEPTH     = 32'd1 << INDEX_BITS;
    localparam logic [CTR_WIDTH-1:0]   CTR_INIT  = CTR_WIDTH'(weak_not_taken(CTR_WIDTH));
    // History is kept INDEX_BITS wide so it zero-extends for free; the mask
    // holds only the low HIST_BITS bits (zero mask = pure bimodal).
    localparam logic [INDEX_BITS-1:0]  HIST_MASK = INDEX_BITS'((64'd1 << HIST_BITS) - 64'd1);
    localparam logic [INDEX_BITS-1:0]  LAST_IDX  = '1;

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [INDEX_BITS-1:0] hist_q, hist_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic                  ready_q, ready_d;

    logic [CTR_WIDTH-1:0]  table_q [DEPTH];

    logic                  wr_en_c;
    logic [INDEX_BITS-1:0] wr_addr_c;
    logic [CTR_WIDTH-1:0]  wr_data_c;
    logic [INDEX_BITS-1:0] req_idx_c;
    logic [CTR_WIDTH-1:0]  upd_ctr_c;
    logic [CTR_WIDTH-1:0]  upd_next_c;
    logic                  unused_pc_c;

    // PC bits outside the hashed field do not participate in the index.
    assign unused_pc_c = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0]};

    assign req_idx_c = pred_pc[INDEX_BITS+1:2] ^ hist_q;
    assign upd_ctr_c = table_q[upd_index];

    bp_sat_next #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_sat_next (
        .count        (upd_ctr_c),
        .taken        (upd_taken),
        .next_count_c (upd_next_c)
    );

    // Next-state, table-write and result computation.
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        hist_d       = hist_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        ready_d      = ready_q;
        wr_en_c      = 1'b0;
        wr_addr_c    = init_idx_q;
        wr_data_c    = CTR_INIT;

        case (state_q)
            ST_INIT: begin
                wr_en_c    = 1'b1;
                init_idx_d = init_idx_q + INDEX_BITS'(1);
                if (init_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Table read uses pre-update contents: the write lands on the edge.
                if (pred_req) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = table_q[req_idx_c][CTR_WIDTH-1];
                    pred_index_d = req_idx_c;
                end
                if (upd_valid) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = upd_index;
                    wr_data_c = upd_next_c;
                    hist_d    = ((hist_q << 1) | INDEX_BITS'(upd_taken)) & HIST_MASK;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            hist_q       <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            hist_q       <= hist_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
            ready_q      <= ready_d;
        end
    end

    // Counter table: single synchronous write port, no reset (INIT sweeps it).
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) table_q[wr_addr_c] <= wr_data_c;
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_index = pred_index_q;
    assign ready      = ready_q;

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter CTR_WIDTH, default 2: bits per saturating counter; SHALL be 2..4.
REQ-002 Parameter INDEX_BITS, default 6: table depth is 2**INDEX_BITS counters.
REQ-003 Parameter HIST_BITS, default 6: global history length; SHALL be 0..INDEX_BITS (0 = pure bimodal).
REQ-004 Parameter PC_WIDTH, default 32: branch address width.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 pred_req  input  1  prediction request this cycle.
REQ-008 pred_pc  input  PC_WIDTH  branch address for the request.
REQ-009 pred_valid  output  1  pred_taken/pred_index are valid.
REQ-010 pred_taken  output  1  predicted direction.
REQ-011 pred_index  output  INDEX_BITS  table index used; the caller returns it with the update.
REQ-012 upd_valid  input  1  resolved-branch update this cycle.
REQ-013 upd_index  input  INDEX_BITS  index from the original prediction.
REQ-014 upd_taken  input  1  resolved direction.
REQ-015 ready  output  1  table initialised; requests and updates are accepted.

Function
REQ-016 Index SHALL be pred_pc[INDEX_BITS+1:2] XOR (global history zero-extended to INDEX_BITS).
REQ-017 Prediction latency SHALL be 1 cycle: pred_req accepted at edge N gives pred_valid=1 during cycle N+1; pred_valid=0 otherwise.
REQ-018 pred_taken SHALL be the MSB of the counter read; pred_index SHALL be the index computed at request time.
REQ-019 An update SHALL increment the counter at upd_index if upd_taken=1 and decrement it otherwise, saturating at all-ones and at zero.
REQ-020 A taken update at all-ones and a not-taken update at zero SHALL leave the counter unchanged; no wrap-around.
REQ-021 Global history SHALL shift left on each accepted update, inserting upd_taken at bit 0 and dropping the MSB; it SHALL NOT change on a prediction.
REQ-022 History used by a prediction SHALL be the value before any update occurring on the same edge.
REQ-023 A same-edge request and update to the same index SHALL read the pre-update counter (read-before-write).
REQ-024 Back-to-back requests every cycle SHALL be supported with one result per cycle.
REQ-025 While ready=0, pred_req and upd_valid SHALL be ignored: no table write, no history change, pred_valid=0.

Reset
REQ-026 rst=1 SHALL force state INIT, history=0, pred_valid=0, pred_taken=0, pred_index=0, ready=0 on the next edge.
REQ-027 INIT SHALL write weakly-not-taken (MSB=0, all lower bits=1; 01 for CTR_WIDTH=2) to one entry per cycle, index 0 upward.
REQ-028 After writing entry 2**INDEX_BITS-1, the state SHALL move to RUN and ready SHALL be 1 from the next cycle; INIT takes exactly 2**INDEX_BITS cycles after rst deasserts.
REQ-029 rst asserted mid-INIT or mid-RUN SHALL restart the sweep from index 0 and discard any in-flight prediction.
REQ-030 The state machine SHALL have exactly two states: INIT (sweep) and RUN (serve); RUN leaves only on rst.

Structure
REQ-031 Package bp_pkg SHALL hold the state enum typedef, the default-parameter constants, and the weakly-not-taken init constant expressed as a function of CTR_WIDTH.
REQ-032 One sub-module, bp_sat_next, SHALL compute the saturating next counter value from (count, taken); this is combinational and is parametrised by CTR_WIDTH.
REQ-033 The table SHALL be a synchronous-write register array inferable as distributed RAM.

Verification
REQ-034 Reset then idle: ready=0 for exactly 64 cycles after rst falls, then 1; a request at pc=0x0 returns pred_taken=0, pred_index=0.
REQ-035 Saturation: 5 taken updates to index 3 give pred_taken=1 and counter 11; a 6th leaves 11; 4 not-taken updates give 00; a 5th leaves 00.
REQ-036 History hashing: updates T,T,N give history 0b000110; a request at pc=0x40 returns pred_index=0x10^0x06=0x16.
REQ-037 Collision: at index 5=01, a same-edge request and taken update return pred_taken=0; the next request returns 1.
REQ-038 Mid-init reset: assert rst at sweep cycle 30 -> ready stays 0 for 64 more cycles; updates issued during that time change no entries.
REQ-039 Parameter sweep: CTR_WIDTH=3, HIST_BITS=0 -> init value 011; 1 taken update -> pred_taken=1; index equals pc[7:2].
